// File: rtl/iob_asym_fifo_ctrl_if.sv
// Request/status bundle between the asymmetric FIFO controller, its producer/consumer and the width converter.
// Widths are derived here from the same parameters the controller uses, so both sides always agree.
interface iob_asym_fifo_ctrl_if #(
    parameter int W_DATA_W = 8,
    parameter int R_DATA_W = 32,
    parameter int ADDR_W   = 4
);
    localparam int MAX_W    = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W;
    localparam int MIN_W    = (W_DATA_W > R_DATA_W) ? R_DATA_W : W_DATA_W;
    localparam int R        = MAX_W / MIN_W;
    localparam int W_INCR   = (W_DATA_W > R_DATA_W) ? R : 1;
    localparam int R_INCR   = (R_DATA_W > W_DATA_W) ? R : 1;
    localparam int W_ADDR_W = ADDR_W - $clog2(W_INCR);
    localparam int R_ADDR_W = ADDR_W - $clog2(R_INCR);

    logic                cke_i;
    logic                flush_i;
    logic                push_i;
    logic                pop_i;
    logic                full_o;
    logic                empty_o;
    logic                r_valid_o;
    logic [ADDR_W:0]     level_o;
    logic                overflow_o;
    logic                underflow_o;
    logic                cvt_w_en_o;
    logic [W_ADDR_W-1:0] cvt_w_addr_o;
    logic                cvt_r_en_o;
    logic [R_ADDR_W-1:0] cvt_r_addr_o;

    // master: producer/consumer side issuing requests
    modport master (
        output cke_i, flush_i, push_i, pop_i,
        input  full_o, empty_o, r_valid_o, level_o, overflow_o, underflow_o,
        input  cvt_w_en_o, cvt_w_addr_o, cvt_r_en_o, cvt_r_addr_o
    );

    // slave: the controller itself
    modport slave (
        input  cke_i, flush_i, push_i, pop_i,
        output full_o, empty_o, r_valid_o, level_o, overflow_o, underflow_o,
        output cvt_w_en_o, cvt_w_addr_o, cvt_r_en_o, cvt_r_addr_o
    );
endinterface

// File: rtl/iob_asym_fifo_ctrl.sv
// Pointer/occupancy controller for an asymmetric-width FIFO; strobes are combinational, r_valid one cycle after pop.
// Backpressure: pushes rejected while full, pops while empty (no bypass), each rejection latched as a sticky error.
module iob_asym_fifo_ctrl #(
    parameter int W_DATA_W = 8,
    parameter int R_DATA_W = 32,
    parameter int ADDR_W   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    iob_asym_fifo_ctrl_if.slave   bus
);
    localparam int MAX_W    = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W;
    localparam int MIN_W    = (W_DATA_W > R_DATA_W) ? R_DATA_W : W_DATA_W;
    localparam int R        = MAX_W / MIN_W;
    localparam int W_INCR   = (W_DATA_W > R_DATA_W) ? R : 1;
    localparam int R_INCR   = (R_DATA_W > W_DATA_W) ? R : 1;
    localparam int W_ADDR_W = ADDR_W - $clog2(W_INCR);
    localparam int R_ADDR_W = ADDR_W - $clog2(R_INCR);

    localparam logic [ADDR_W:0] CAP      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] W_INC_L  = W_INCR[ADDR_W:0];
    localparam logic [ADDR_W:0] R_INC_L  = R_INCR[ADDR_W:0];
    localparam logic [ADDR_W:0] FULL_THR = CAP - W_INC_L;

    logic [W_ADDR_W-1:0] w_ptr;
    logic [R_ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]     level;
    logic [ADDR_W:0]     level_nxt;
    logic                r_valid;
    logic                overflow;
    logic                underflow;
    logic                full;
    logic                empty;
    logic                w_acc;
    logic                r_acc;
    logic                w_rej;
    logic                r_rej;

    assign full  = (level > FULL_THR);
    assign empty = (level < R_INC_L);

    // Reset and flush both suppress the converter strobes so stale requests never touch the RAM.
    always_comb begin
        w_acc = 1'b0;
        r_acc = 1'b0;
        if (rst_n_i && bus.cke_i && !bus.flush_i) begin
            w_acc = bus.push_i && !full;
            r_acc = bus.pop_i  && !empty;
        end
    end

    assign w_rej = bus.cke_i & bus.push_i & full;
    assign r_rej = bus.cke_i & bus.pop_i  & empty;

    always_comb begin
        level_nxt = level;
        if (w_acc) level_nxt = level_nxt + W_INC_L;
        if (r_acc) level_nxt = level_nxt - R_INC_L;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            level     <= '0;
            r_valid   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (bus.cke_i) begin
            if (bus.flush_i) begin
                w_ptr     <= '0;
                r_ptr     <= '0;
                level     <= '0;
                r_valid   <= 1'b0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (w_acc) w_ptr <= w_ptr + 1'b1;
                if (r_acc) r_ptr <= r_ptr + 1'b1;
                level     <= level_nxt;
                r_valid   <= r_acc;
                overflow  <= overflow  | w_rej;
                underflow <= underflow | r_rej;
            end
        end
    end

    assign bus.full_o       = full;
    assign bus.empty_o      = empty;
    assign bus.level_o      = level;
    assign bus.r_valid_o    = r_valid;
    assign bus.overflow_o   = overflow;
    assign bus.underflow_o  = underflow;
    assign bus.cvt_w_en_o   = w_acc;
    assign bus.cvt_w_addr_o = w_ptr;
    assign bus.cvt_r_en_o   = r_acc;
    assign bus.cvt_r_addr_o = r_ptr;
endmodule

// File: tb/tb_iob_asym_fifo_ctrl.sv
// Directed bench: 8->32 instance (a) for the main scenarios, 32->8 instance (b) for the wide-write case.
module tb_iob_asym_fifo_ctrl;
    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk_i = ~clk_i;

    iob_asym_fifo_ctrl_if #(.W_DATA_W(8),  .R_DATA_W(32), .ADDR_W(4)) a_if ();
    iob_asym_fifo_ctrl_if #(.W_DATA_W(32), .R_DATA_W(8),  .ADDR_W(4)) b_if ();

    iob_asym_fifo_ctrl #(.W_DATA_W(8),  .R_DATA_W(32), .ADDR_W(4)) dut_a (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .bus(a_if.slave));
    iob_asym_fifo_ctrl #(.W_DATA_W(32), .R_DATA_W(8),  .ADDR_W(4)) dut_b (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .bus(b_if.slave));

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        a_if.push_i = 1'b1;
        tick(); tick();
        n_tests++; if (a_if.level_o !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", a_if.level_o); end
        n_tests++; if (a_if.empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %0b exp 1", a_if.empty_o); end
        n_tests++; if (a_if.full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b exp 0", a_if.full_o); end
        n_tests++; if ({a_if.cvt_w_en_o, a_if.cvt_r_en_o, a_if.r_valid_o, a_if.overflow_o, a_if.underflow_o} !== 5'b0)
            begin n_fail++; $display("FAIL reset_flags got %b exp 00000",
                {a_if.cvt_w_en_o, a_if.cvt_r_en_o, a_if.r_valid_o, a_if.overflow_o, a_if.underflow_o}); end
        a_if.push_i = 1'b0;
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_first_push();
        a_if.push_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (a_if.empty_o !== 1'b1) begin n_fail++; $display("FAIL first_push_empty%0d got %0b exp 1", i, a_if.empty_o); end
        end
        tick();
        a_if.push_i = 1'b0;
        n_tests++; if (a_if.empty_o !== 1'b0) begin n_fail++; $display("FAIL fourth_push_empty got %0b exp 0", a_if.empty_o); end
        n_tests++; if (a_if.level_o !== 5'd4) begin n_fail++; $display("FAIL fourth_push_level got %0d exp 4", a_if.level_o); end
    endtask

    task automatic test_fill_full();
        rst_n_i = 1'b0; tick(); rst_n_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_if.push_i = 1'b1;
            #1;
            n_tests++; if (a_if.cvt_w_en_o !== 1'b1 || a_if.cvt_w_addr_o !== 4'(i))
                begin n_fail++; $display("FAIL fill_waddr%0d got en=%0b addr=%0d exp en=1 addr=%0d", i, a_if.cvt_w_en_o, a_if.cvt_w_addr_o, i); end
            tick();
        end
        n_tests++; if (a_if.full_o !== 1'b1) begin n_fail++; $display("FAIL fill_full got %0b exp 1", a_if.full_o); end
        n_tests++; if (a_if.level_o !== 5'd16) begin n_fail++; $display("FAIL fill_level got %0d exp 16", a_if.level_o); end
        #1;
        n_tests++; if (a_if.cvt_w_en_o !== 1'b0) begin n_fail++; $display("FAIL over_wen got %0b exp 0", a_if.cvt_w_en_o); end
        tick();
        a_if.push_i = 1'b0;
        n_tests++; if (a_if.overflow_o !== 1'b1) begin n_fail++; $display("FAIL overflow got %0b exp 1", a_if.overflow_o); end
        n_tests++; if (a_if.level_o !== 5'd16) begin n_fail++; $display("FAIL over_level got %0d exp 16", a_if.level_o); end
    endtask

    task automatic test_drain_wrap();
        for (int i = 0; i < 4; i++) begin
            a_if.pop_i = 1'b1;
            #1;
            n_tests++; if (a_if.cvt_r_en_o !== 1'b1 || a_if.cvt_r_addr_o !== 2'(i))
                begin n_fail++; $display("FAIL drain_raddr%0d got en=%0b addr=%0d exp en=1 addr=%0d", i, a_if.cvt_r_en_o, a_if.cvt_r_addr_o, i); end
            tick();
            n_tests++; if (a_if.r_valid_o !== 1'b1) begin n_fail++; $display("FAIL drain_rvalid%0d got %0b exp 1", i, a_if.r_valid_o); end
        end
        a_if.pop_i = 1'b0;
        tick();
        n_tests++; if (a_if.r_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_rvalid_fall got %0b exp 0", a_if.r_valid_o); end
        n_tests++; if (a_if.level_o !== 5'd0 || a_if.empty_o !== 1'b1)
            begin n_fail++; $display("FAIL drain_level got %0d empty=%0b exp 0 empty=1", a_if.level_o, a_if.empty_o); end
        for (int i = 0; i < 4; i++) begin
            a_if.push_i = 1'b1;
            #1;
            n_tests++; if (a_if.cvt_w_addr_o !== 4'(i)) begin n_fail++; $display("FAIL wrap_waddr%0d got %0d exp %0d", i, a_if.cvt_w_addr_o, i); end
            tick();
        end
        a_if.push_i = 1'b0;
        a_if.pop_i = 1'b1;
        #1;
        n_tests++; if (a_if.cvt_r_en_o !== 1'b1 || a_if.cvt_r_addr_o !== 2'd0)
            begin n_fail++; $display("FAIL wrap_raddr got en=%0b addr=%0d exp en=1 addr=0", a_if.cvt_r_en_o, a_if.cvt_r_addr_o); end
        tick();
        a_if.pop_i = 1'b0;
        n_tests++; if (a_if.level_o !== 5'd0) begin n_fail++; $display("FAIL wrap_level got %0d exp 0", a_if.level_o); end
    endtask

    task automatic test_simultaneous();
        a_if.push_i = 1'b1;
        repeat (4) tick();
        a_if.pop_i = 1'b1;
        #1;
        n_tests++; if (a_if.cvt_w_en_o !== 1'b1 || a_if.cvt_r_en_o !== 1'b1)
            begin n_fail++; $display("FAIL sim4_en got w=%0b r=%0b exp w=1 r=1", a_if.cvt_w_en_o, a_if.cvt_r_en_o); end
        tick();
        a_if.pop_i = 1'b0;
        n_tests++; if (a_if.level_o !== 5'd1) begin n_fail++; $display("FAIL sim4_level got %0d exp 1", a_if.level_o); end
        repeat (2) tick();
        a_if.pop_i = 1'b1;
        #1;
        n_tests++; if (a_if.cvt_w_en_o !== 1'b1 || a_if.cvt_r_en_o !== 1'b0)
            begin n_fail++; $display("FAIL sim3_en got w=%0b r=%0b exp w=1 r=0", a_if.cvt_w_en_o, a_if.cvt_r_en_o); end
        tick();
        a_if.pop_i = 1'b0;
        a_if.push_i = 1'b0;
        n_tests++; if (a_if.level_o !== 5'd4) begin n_fail++; $display("FAIL sim3_level got %0d exp 4", a_if.level_o); end
        n_tests++; if (a_if.underflow_o !== 1'b1) begin n_fail++; $display("FAIL sim3_underflow got %0b exp 1", a_if.underflow_o); end
    endtask

    task automatic test_flush();
        a_if.push_i = 1'b1;
        repeat (4) tick();
        n_tests++; if (a_if.level_o !== 5'd8 || a_if.overflow_o !== 1'b1)
            begin n_fail++; $display("FAIL flush_pre got level=%0d ovf=%0b exp level=8 ovf=1", a_if.level_o, a_if.overflow_o); end
        a_if.flush_i = 1'b1;
        #1;
        n_tests++; if (a_if.cvt_w_en_o !== 1'b0) begin n_fail++; $display("FAIL flush_wen got %0b exp 0", a_if.cvt_w_en_o); end
        tick();
        a_if.flush_i = 1'b0;
        a_if.push_i = 1'b0;
        n_tests++; if (a_if.level_o !== 5'd0 || a_if.overflow_o !== 1'b0 || a_if.underflow_o !== 1'b0)
            begin n_fail++; $display("FAIL flush_state got level=%0d ovf=%0b udf=%0b exp 0 0 0", a_if.level_o, a_if.overflow_o, a_if.underflow_o); end
    endtask

    task automatic test_reset_mid();
        a_if.push_i = 1'b1;
        repeat (17) tick();
        a_if.push_i = 1'b0;
        a_if.pop_i = 1'b1;
        repeat (2) tick();
        a_if.pop_i = 1'b0;
        a_if.cke_i = 1'b0;
        a_if.push_i = 1'b1;
        #1;
        n_tests++; if (a_if.cvt_w_en_o !== 1'b0) begin n_fail++; $display("FAIL cke_wen got %0b exp 0", a_if.cvt_w_en_o); end
        tick();
        n_tests++; if (a_if.level_o !== 5'd8 || a_if.r_valid_o !== 1'b1 || a_if.overflow_o !== 1'b1)
            begin n_fail++; $display("FAIL cke_hold got level=%0d rv=%0b ovf=%0b exp 8 1 1", a_if.level_o, a_if.r_valid_o, a_if.overflow_o); end
        rst_n_i = 1'b0;
        tick();
        n_tests++; if (a_if.level_o !== 5'd0 || a_if.overflow_o !== 1'b0 || a_if.r_valid_o !== 1'b0 || a_if.cvt_w_en_o !== 1'b0)
            begin n_fail++; $display("FAIL rst_mid got level=%0d ovf=%0b rv=%0b wen=%0b exp 0 0 0 0",
                a_if.level_o, a_if.overflow_o, a_if.r_valid_o, a_if.cvt_w_en_o); end
        a_if.push_i = 1'b0;
        a_if.cke_i = 1'b1;
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_wide_write();
        b_if.push_i = 1'b1;
        #1;
        n_tests++; if (b_if.cvt_w_en_o !== 1'b1 || b_if.cvt_w_addr_o !== 2'd0)
            begin n_fail++; $display("FAIL wide_wen got en=%0b addr=%0d exp 1 0", b_if.cvt_w_en_o, b_if.cvt_w_addr_o); end
        tick();
        n_tests++; if (b_if.level_o !== 5'd4 || b_if.empty_o !== 1'b0)
            begin n_fail++; $display("FAIL wide_level1 got %0d empty=%0b exp 4 0", b_if.level_o, b_if.empty_o); end
        repeat (3) tick();
        b_if.push_i = 1'b0;
        b_if.pop_i = 1'b1;
        repeat (3) tick();
        n_tests++; if (b_if.level_o !== 5'd13 || b_if.full_o !== 1'b1)
            begin n_fail++; $display("FAIL wide_13 got level=%0d full=%0b exp 13 1", b_if.level_o, b_if.full_o); end
        b_if.push_i = 1'b1;
        #1;
        n_tests++; if (b_if.cvt_w_en_o !== 1'b0 || b_if.cvt_r_en_o !== 1'b1 || b_if.cvt_r_addr_o !== 4'd3)
            begin n_fail++; $display("FAIL wide_sim got w=%0b r=%0b raddr=%0d exp 0 1 3", b_if.cvt_w_en_o, b_if.cvt_r_en_o, b_if.cvt_r_addr_o); end
        tick();
        b_if.push_i = 1'b0;
        b_if.pop_i = 1'b0;
        n_tests++; if (b_if.level_o !== 5'd12 || b_if.overflow_o !== 1'b1 || b_if.full_o !== 1'b0)
            begin n_fail++; $display("FAIL wide_12 got level=%0d ovf=%0b full=%0b exp 12 1 0", b_if.level_o, b_if.overflow_o, b_if.full_o); end
    endtask

    initial begin
        a_if.cke_i = 1'b1; a_if.flush_i = 1'b0; a_if.push_i = 1'b0; a_if.pop_i = 1'b0;
        b_if.cke_i = 1'b1; b_if.flush_i = 1'b0; b_if.push_i = 1'b0; b_if.pop_i = 1'b0;
        #2;
        test_reset();
        test_first_push();
        test_fill_full();
        test_drain_wrap();
        test_simultaneous();
        test_flush();
        test_reset_mid();
        test_wide_write();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
